// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared next-PC encodings, fetch FSM states and reset PC
package cpu_pkg;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef enum logic [1:0] {
    PCS_SEQ = 2'b00,
    PCS_JR  = 2'b01,
    PCS_BR  = 2'b10,
    PCS_J   = 2'b11
  } pc_sel_e;

  typedef enum logic [1:0] {
    FETCH = 2'b00,
    WAIT  = 2'b01,
    ISSUE = 2'b10,
    HALT  = 2'b11
  } fetch_state_e;

  // Word offset of a conditional branch: sign-extended immediate scaled by 4.
  function automatic logic [31:0] branch_offset(input logic [15:0] imm);
    return {{14{imm[15]}}, imm, 2'b00};
  endfunction

endpackage

// File: rtl/next_pc_calc.sv
// rtl/next_pc_calc.sv - combinational next-PC selection with jr alignment check
module next_pc_calc
  import cpu_pkg::*;
(
  input  logic [31:0] pc,
  input  logic [31:0] pc_plus4,
  input  logic [25:0] inst_idx,
  input  logic [31:0] rs_data,
  input  logic [1:0]  pc_s,
  output logic [31:0] next_pc,
  output logic        misalign
);

  always_comb begin
    next_pc  = pc_plus4;
    misalign = 1'b0;
    case (pc_s)
      PCS_SEQ: next_pc = pc_plus4;
      PCS_JR: begin
        // A misaligned register target leaves the PC where it is.
        if (rs_data[1:0] != 2'b00) begin
          misalign = 1'b1;
          next_pc  = pc;
        end else begin
          next_pc = rs_data;
        end
      end
      PCS_BR:  next_pc = pc_plus4 + branch_offset(inst_idx[15:0]);
      PCS_J:   next_pc = {pc_plus4[31:28], inst_idx, 2'b00};
    endcase
  end

endmodule

// File: rtl/pc_fetch_unit.sv
// rtl/pc_fetch_unit.sv - program counter and single-outstanding instruction fetch
module pc_fetch_unit
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  PC_s,
  input  logic [31:0] rs_data,
  input  logic        inst_ack,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] inst,
  output logic        inst_valid,
  output logic [5:0]  op,
  output logic [5:0]  func,
  output logic [31:0] PC,
  output logic [31:0] PC_plus4,
  output logic        misalign_err
);

  fetch_state_e state, state_next;
  logic [31:0]  pc_q;
  logic [31:0]  inst_q;
  logic         misalign_q;
  logic [31:0]  next_pc;
  logic         misalign;

  assign PC           = pc_q;
  assign PC_plus4     = pc_q + 32'd4;
  assign imem_addr    = pc_q;
  assign inst         = inst_q;
  assign op           = inst_q[31:26];
  assign func         = inst_q[5:0];
  assign misalign_err = misalign_q;

  next_pc_calc u_next_pc_calc (
    .pc       (pc_q),
    .pc_plus4 (PC_plus4),
    .inst_idx (inst_q[25:0]),
    .rs_data  (rs_data),
    .pc_s     (PC_s),
    .next_pc  (next_pc),
    .misalign (misalign)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= FETCH;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    imem_req   = 1'b0;
    inst_valid = 1'b0;
    case (state)
      FETCH: begin
        // Request is suppressed during the reset cycle itself.
        imem_req = !rst;
        if (imem_ready) state_next = WAIT;
      end
      WAIT: begin
        if (imem_rvalid) state_next = ISSUE;
      end
      ISSUE: begin
        inst_valid = 1'b1;
        if (inst_ack) state_next = misalign ? HALT : FETCH;
      end
      HALT: begin
        state_next = HALT;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q       <= RESET_PC;
      inst_q     <= 32'h0000_0000;
      misalign_q <= 1'b0;
    end else begin
      if (state == WAIT && imem_rvalid) begin
        inst_q <= imem_rdata;
      end
      if (state == ISSUE && inst_ack) begin
        if (misalign) begin
          misalign_q <= 1'b1;
        end else begin
          pc_q <= next_pc;
        end
      end
    end
  end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// tb/tb_pc_fetch_unit.sv - scoreboard bench for pc_fetch_unit
module tb_pc_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  PC_s;
  logic [31:0] rs_data;
  logic        inst_ack;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic [31:0] inst;
  logic        inst_valid;
  logic [5:0]  op;
  logic [5:0]  func;
  logic [31:0] PC;
  logic [31:0] PC_plus4;
  logic        misalign_err;

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] sb_q[$];
  logic [31:0] cur_pc;
  logic [31:0] cur_inst;

  always #5 clk = ~clk;

  pc_fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk          (clk),
    .rst          (rst),
    .PC_s         (PC_s),
    .rs_data      (rs_data),
    .inst_ack     (inst_ack),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_ready   (imem_ready),
    .imem_rvalid  (imem_rvalid),
    .imem_rdata   (imem_rdata),
    .inst         (inst),
    .inst_valid   (inst_valid),
    .op           (op),
    .func         (func),
    .PC           (PC),
    .PC_plus4     (PC_plus4),
    .misalign_err (misalign_err)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] model_next(input logic [31:0] pc, input logic [31:0] iw,
                                             input logic [1:0] sel, input logic [31:0] rs);
    logic [31:0] p4;
    int          off;
    p4  = pc + 32'd4;
    off = int'($signed(iw[15:0]));
    case (sel)
      2'b00:   return p4;
      2'b01:   return rs;
      2'b10:   return 32'(p4 + 32'(off * 4));
      default: return {p4[31:28], iw[25:0], 2'b00};
    endcase
  endfunction

  // Fetch one word: optional ready stalls with stray rvalid / ack, then accept and return data.
  task automatic fetch(input int stall, input logic [31:0] word);
    logic [31:0] ea;
    ea = (sb_q.size() > 0) ? sb_q.pop_front() : 32'hDEAD_BEEF;
    chk("fetch_req", 32'(imem_req), 32'd1);
    chk("fetch_addr", imem_addr, ea);
    for (int i = 0; i < stall; i++) begin
      imem_ready  = 1'b0;
      imem_rvalid = (i == 1);
      imem_rdata  = 32'hBAD0_0000;
      inst_ack    = (i == 0);
      PC_s        = 2'b01;
      rs_data     = 32'h0000_3000;
      @(negedge clk);
      chk("stall_req", 32'(imem_req), 32'd1);
      chk("stall_addr", imem_addr, ea);
      chk("stall_valid", 32'(inst_valid), 32'd0);
    end
    imem_rvalid = 1'b0;
    inst_ack    = 1'b0;
    imem_ready  = 1'b1;
    @(negedge clk);
    imem_ready = 1'b0;
    chk("wait_req", 32'(imem_req), 32'd0);
    chk("wait_valid", 32'(inst_valid), 32'd0);
    imem_rvalid = 1'b1;
    imem_rdata  = word;
    @(negedge clk);
    imem_rvalid = 1'b0;
    chk("issue_valid", 32'(inst_valid), 32'd1);
    chk("issue_inst", inst, word);
    chk("issue_op", 32'(op), 32'(word[31:26]));
    chk("issue_func", 32'(func), 32'(word[5:0]));
    chk("issue_pc", PC, ea);
    chk("issue_pc4", PC_plus4, ea + 32'd4);
    cur_pc   = ea;
    cur_inst = word;
  endtask

  task automatic issue(input logic [1:0] sel, input logic [31:0] rs);
    logic [31:0] exp;
    imem_rvalid = 1'b1;
    imem_rdata  = 32'h1234_5678;
    @(negedge clk);
    imem_rvalid = 1'b0;
    chk("stray_inst", inst, cur_inst);
    chk("stray_valid", 32'(inst_valid), 32'd1);
    inst_ack = 1'b1;
    PC_s     = sel;
    rs_data  = rs;
    @(negedge clk);
    inst_ack = 1'b0;
    if (sel == 2'b01 && rs[1:0] != 2'b00) begin
      chk("mis_err", 32'(misalign_err), 32'd1);
      chk("mis_req", 32'(imem_req), 32'd0);
      chk("mis_valid", 32'(inst_valid), 32'd0);
      chk("mis_pc", imem_addr, cur_pc);
    end else begin
      exp = model_next(cur_pc, cur_inst, sel, rs);
      sb_q.push_back(exp);
      chk("ack_req", 32'(imem_req), 32'd1);
      chk("ack_addr", imem_addr, exp);
      chk("ack_err", 32'(misalign_err), 32'd0);
    end
  endtask

  initial begin
    logic [31:0] ea;
    rst = 1'b1; PC_s = 2'b00; rs_data = '0; inst_ack = 1'b0;
    imem_ready = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_req", 32'(imem_req), 32'd0);
    chk("rst_valid", 32'(inst_valid), 32'd0);
    chk("rst_pc", PC, 32'h0);
    chk("rst_inst", inst, 32'h0);
    chk("rst_err", 32'(misalign_err), 32'd0);
    rst = 1'b0;
    #1;
    chk("post_rst_req", 32'(imem_req), 32'd1);
    sb_q.push_back(32'h0000_0000);

    fetch(0, 32'h2001_0005);
    issue(2'b00, 32'h0);
    fetch(3, {6'h02, 26'h000_0040});
    issue(2'b11, 32'h0);
    fetch(0, {6'h04, 5'd1, 5'd2, 16'hFFFE});
    issue(2'b10, 32'h0);
    fetch(2, 32'h0000_0008);
    issue(2'b01, 32'h0000_2000);
    fetch(0, 32'h0000_0008);
    issue(2'b01, 32'h0040_0010);
    fetch(1, {6'h02, 26'h000_0100});
    issue(2'b11, 32'h0);

    // Reset while waiting for read data.
    ea = (sb_q.size() > 0) ? sb_q.pop_front() : 32'hDEAD_BEEF;
    chk("pre_wait_addr", imem_addr, ea);
    imem_ready = 1'b1;
    @(negedge clk);
    imem_ready = 1'b0;
    chk("w_req", 32'(imem_req), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    chk("wrst_addr", imem_addr, 32'h0);
    chk("wrst_valid", 32'(inst_valid), 32'd0);
    chk("wrst_req", 32'(imem_req), 32'd0);
    rst = 1'b0;
    #1;
    chk("wrst_req_after", 32'(imem_req), 32'd1);
    sb_q.push_back(32'h0000_0000);

    fetch(0, 32'h0000_0008);
    issue(2'b01, 32'hFFFF_FFFC);
    fetch(0, 32'h0000_0020);
    issue(2'b00, 32'h0);
    fetch(0, 32'h0000_0008);
    issue(2'b01, 32'h0000_2002);

    for (int i = 0; i < 4; i++) begin
      imem_ready  = 1'b1;
      imem_rvalid = 1'b1;
      inst_ack    = 1'b1;
      @(negedge clk);
      chk("halt_req", 32'(imem_req), 32'd0);
      chk("halt_valid", 32'(inst_valid), 32'd0);
      chk("halt_err", 32'(misalign_err), 32'd1);
    end
    imem_ready = 1'b0; imem_rvalid = 1'b0; inst_ack = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("hrst_err", 32'(misalign_err), 32'd0);
    chk("hrst_req", 32'(imem_req), 32'd1);
    chk("hrst_addr", imem_addr, 32'h0);
    chk("sb_left", 32'(sb_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pc_fetch_unit.md
PC_FETCH_UNIT -- requirements
Module: pc_fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, PC value loaded on reset (word aligned).
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 PC_s  input  2  next-PC select from controller: 00 PC+4, 01 rs_data (jr), 10 branch target, 11 jump target.
REQ-005 rs_data  input  32  register-file rs read value (jr target).
REQ-006 inst_ack  input  1  core has executed inst; PC_s/rs_data valid this cycle.
REQ-007 imem_req  output  1  instruction memory read request.
REQ-008 imem_addr  output  32  read address (current PC).
REQ-009 imem_ready  input  1  memory accepts request this cycle.
REQ-010 imem_rvalid  input  1  read data valid.
REQ-011 imem_rdata  input  32  instruction word.
REQ-012 inst  output  32  held instruction.
REQ-013 inst_valid  output  1  inst is valid, awaiting inst_ack.
REQ-014 op  output  6  inst[31:26]; func  output  6  inst[5:0].
REQ-015 PC  output  32  address of inst; PC_plus4  output  32  PC+4 (jal link value).
REQ-016 misalign_err  output  1  sticky jr misalignment flag.

Function
REQ-017 FSM states: FETCH, WAIT, ISSUE, HALT.
REQ-018 FETCH: imem_req=1, imem_addr=PC; go to WAIT on imem_ready=1, else stay with address held.
REQ-019 WAIT: imem_req=0; on imem_rvalid capture imem_rdata into inst, go to ISSUE; imem_rvalid outside WAIT ignored.
REQ-020 ISSUE: inst_valid=1, inst/op/func/PC stable; on inst_ack update PC per PC_s, go to FETCH next cycle.
REQ-021 Branch target = PC_plus4 + (sign-extended inst[15:0] << 2), 32-bit modulo arithmetic.
REQ-022 Jump target = {PC_plus4[31:28], inst[25:0], 2'b00}.
REQ-023 jr with rs_data[1:0]!=0: set misalign_err, PC unchanged, go to HALT.
REQ-024 HALT: imem_req=0, inst_valid=0; exit only by reset.
REQ-025 PC+4 wraps 32'hFFFF_FFFC -> 32'h0000_0000 without error.
REQ-026 Latency: inst_ack in cycle t -> new PC and imem_req=1 in cycle t+1; minimum fetch-to-issue: accept n, rvalid n+1, inst_valid n+2.
REQ-027 inst_ack while inst_valid=0 has no effect.

Reset
REQ-028 On rst: state FETCH, PC=RESET_PC, inst=0, inst_valid=0, misalign_err=0, imem_req=0 in reset cycle, 1 from first cycle after.
REQ-029 Reset mid-operation (any state) discards captured/pending instruction; memory shares rst, no late response expected.

Structure
REQ-030 Shared package cpu_pkg: PC_s encodings (PCS_SEQ, PCS_JR, PCS_BR, PCS_J), FSM state enum, default RESET_PC.
REQ-031 One combinational sub-module next_pc_calc (PC, inst, rs_data, PC_s -> next PC, misalign).

Verification
REQ-032 Reset, imem_ready=1, rvalid 1 cycle later -> imem_addr=0, inst_valid 2 cycles after request accepted, PC_plus4=4.
REQ-033 PC=0x100, beq inst imm=0xFFFE, PC_s=10, ack -> next imem_addr=0x0FC.
REQ-034 PC=0x0040_0010, j inst target field 0x0000100, PC_s=11 -> imem_addr=0x0000_0400.
REQ-035 jr rs_data=0x0000_2002 -> misalign_err=1, HALT, imem_req stays 0 until rst; rs_data=0x2000 -> imem_addr=0x2000.
REQ-036 imem_ready low 3 cycles -> imem_req/imem_addr held stable; stray rvalid during FETCH/ISSUE ignored.
REQ-037 rst asserted in WAIT -> next cycle FETCH at RESET_PC, inst_valid=0.
